count_run_controller: RTL

//  Run/pause/clear sequencer for the N-bit CountNG counter on the DE2 board.

---
 rtl/count_run_if.sv | 26 ++
 rtl/count_run_controller.sv | 136 +++++++++++++
 2 files changed

// File: rtl/count_run_if.sv
// Button, limit and counter-feedback bundle between the board side and the
// run controller; the controller uses the slave modport.
interface count_run_if #(
   parameter int unsigned N = 16
);
   logic         start_stop;
   logic         clear_req;
   logic         wrap;
   logic [N-1:0] limit;
   logic [N-1:0] q;
   logic         not_enable;
   logic         clear;
   logic         tick;
   logic         running;
   logic         done;

   modport master (
      output start_stop, clear_req, wrap, limit, q,
      input  not_enable, clear, tick, running, done
   );

   modport slave (
      input  start_stop, clear_req, wrap, limit, q,
      output not_enable, clear, tick, running, done
   );
endinterface

// File: rtl/count_run_controller.sv
// Stopwatch-style run/pause/clear sequencer for an N-bit counter: conditions the
// raw buttons, prescales the clock and enforces a terminal limit (stop or wrap).
module count_run_controller #(
   parameter int unsigned N     = 16,
   parameter int unsigned DIV   = 50000000,
   parameter int unsigned DIV_W = 26
) (
   input logic        clock,
   input logic        resetn,
   count_run_if.slave bus
);
   typedef enum logic [2:0] {CLR, IDLE, RUN, PAUSE, DONE} state_t;

   localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV - 1);

   state_t           state;
   logic [DIV_W-1:0] presc;
   logic [2:0]       ss_sync;
   logic [2:0]       clr_sync;
   logic             ss_pulse;
   logic             clr_pulse;
   logic [N-1:0]     q;
   logic [N-1:0]     limit;
   logic             at_limit;
   logic             terminal;

   logic             not_enable_r;
   logic             clear_r;
   logic             tick_r;
   logic             running_r;
   logic             done_r;

   assign q        = bus.q;
   assign limit    = bus.limit;
   assign at_limit = (q == limit);
   assign terminal = (presc == TERM);

   // Two sync stages, third stage only feeds the rising-edge detector.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ss_sync  <= '0;
         clr_sync <= '0;
      end else begin
         ss_sync  <= {ss_sync[1:0], bus.start_stop};
         clr_sync <= {clr_sync[1:0], bus.clear_req};
      end
   end

   assign ss_pulse  = ss_sync[1] & ~ss_sync[2];
   assign clr_pulse = clr_sync[1] & ~clr_sync[2];

   // Sequencer: clear beats start/stop, and any button beats a same-cycle terminal event.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= CLR;
         presc        <= '0;
         not_enable_r <= 1'b1;
         clear_r      <= 1'b1;
         tick_r       <= 1'b0;
         running_r    <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         not_enable_r <= 1'b1;
         clear_r      <= 1'b0;
         tick_r       <= 1'b0;
         case (state)
            CLR: begin
               state     <= IDLE;
               running_r <= 1'b0;
               done_r    <= 1'b0;
            end
            IDLE: begin
               if (clr_pulse) begin
                  state   <= CLR;
                  clear_r <= 1'b1;
               end else if (ss_pulse) begin
                  state     <= RUN;
                  presc     <= '0;
                  running_r <= 1'b1;
               end
            end
            RUN: begin
               if (clr_pulse) begin
                  state     <= CLR;
                  clear_r   <= 1'b1;
                  running_r <= 1'b0;
               end else if (ss_pulse) begin
                  state     <= PAUSE;
                  running_r <= 1'b0;
               end else if (terminal) begin
                  presc <= '0;
                  if (!at_limit) begin
                     not_enable_r <= 1'b0;
                     tick_r       <= 1'b1;
                  end else if (bus.wrap) begin
                     clear_r <= 1'b1;
                     tick_r  <= 1'b1;
                  end else begin
                     state     <= DONE;
                     running_r <= 1'b0;
                     done_r    <= 1'b1;
                  end
               end else begin
                  presc <= presc + DIV_W'(1);
               end
            end
            PAUSE: begin
               if (clr_pulse) begin
                  state   <= CLR;
                  clear_r <= 1'b1;
               end else if (ss_pulse) begin
                  state     <= RUN;
                  running_r <= 1'b1;
               end
            end
            DONE: begin
               if (clr_pulse) begin
                  state   <= CLR;
                  clear_r <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state   <= CLR;
               clear_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.not_enable = not_enable_r;
   assign bus.clear      = clear_r;
   assign bus.tick       = tick_r;
   assign bus.running    = running_r;
   assign bus.done       = done_r;
endmodule
